branch_predict_unit: RTL and testbench

Parametrised successor to the pipeline's branch resolution logic. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, a fetch-stage prediction port and an execute-stage resolve/update port. It raises a redirect when a prediction was wrong and latches a sticky halt state. It sits between IF (lookup) and EX (resolve) and drives the PC mux and the IF/ID and ID/EX flush.

---
 rtl/bpu_pkg.sv | 34 +++
 rtl/branch_predict_unit_if.sv | 54 +++++
 rtl/branch_predict_unit_btb.sv | 47 ++++
 rtl/branch_predict_unit.sv | 201 ++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_pkg
//  Description : Shared types and constants for the branch prediction unit.
//                Holds the FSM state enum, the 2-bit direction counter
//                constants and a saturating counter helper.
//                The BTB entry struct depends on PC_W/ENTRIES, so its layout
//                is declared from localparams inside branch_predict_unit.
//  Revision    : 1.0  initial release
// ============================================================================
package bpu_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } bpu_state_e;

    localparam logic [1:0] CTR_INIT = 2'd2;
    localparam logic [1:0] CTR_MAX  = 2'd3;

    // 2-bit saturating up/down step for the direction counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) r = ctr + 2'd1;
        end else begin
            if (ctr != 2'd0) r = ctr - 2'd1;
        end
        return r;
    endfunction

endpackage : bpu_pkg
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit_if
//  Description : Pipeline-side bundle of the branch prediction unit.
//                master : the pipeline (drives fetch PC and EX resolve info)
//                slave  : the branch prediction unit
//  Signals     : f_pc / f_pred_taken / f_pred_target      - IF lookup
//                ex_*                                     - EX resolve inputs
//                redirect / redirect_pc / flush / pc_four - PC mux, flush
//                branch_count / mispredict_count          - perf counters
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_predict_unit_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 32
);
    logic [PC_W-1:0]  f_pc;
    logic             f_pred_taken;
    logic [PC_W-1:0]  f_pred_target;

    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_branch;
    logic             ex_jal;
    logic             ex_jalr;
    logic             ex_halt;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_alu_result;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_target;

    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush;
    logic [PC_W-1:0]  pc_four;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output f_pc, ex_valid, ex_pc, ex_branch, ex_jal, ex_jalr, ex_halt,
               ex_imm, ex_alu_result, ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_pred_target, redirect, redirect_pc, flush,
               pc_four, branch_count, mispredict_count
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_branch, ex_jal, ex_jalr, ex_halt,
               ex_imm, ex_alu_result, ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_pred_target, redirect, redirect_pc, flush,
               pc_four, branch_count, mispredict_count
    );

endinterface : branch_predict_unit_if
`default_nettype wire

// File: rtl/branch_predict_unit_btb.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Direct-mapped entry storage. Two asynchronous read ports
//                (fetch lookup, EX lookup), one synchronous write port and an
//                asynchronous clear of every entry. Entry layout is opaque
//                here; an all-zero word is an invalid entry with ctr = 0.
//  Ports       : clk, rst_n                 - clock, active-low async reset
//                rd_a_idx_i / rd_a_entry_o  - read port A
//                rd_b_idx_i / rd_b_entry_o  - read port B
//                wr_en_i, wr_idx_i, wr_entry_i - write port
//  Revision    : 1.0  initial release
// ============================================================================
module branch_target_buffer #(
    parameter  int ENTRY_W = 16,
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic [IDX_W-1:0]   rd_a_idx_i,
    output logic      [ENTRY_W-1:0] rd_a_entry_o,
    input  wire logic [IDX_W-1:0]   rd_b_idx_i,
    output logic      [ENTRY_W-1:0] rd_b_entry_o,
    input  wire logic               wr_en_i,
    input  wire logic [IDX_W-1:0]   wr_idx_i,
    input  wire logic [ENTRY_W-1:0] wr_entry_i
);

    logic [ENTRY_W-1:0] mem_q [ENTRIES];

    // Reads return the pre-write contents during a write cycle (no bypass).
    assign rd_a_entry_o = mem_q[rd_a_idx_i];
    assign rd_b_entry_o = mem_q[rd_b_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end
    end

endmodule : branch_target_buffer
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : BTB-based branch predictor with EX-stage resolve, redirect
//                generation, sticky HALT state and saturating perf counters.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-low reset
//                bus    - branch_predict_unit_if.slave (IF lookup, EX
//                         resolve, redirect/flush, perf counters)
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    branch_predict_unit_if.slave bus
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = PC_W - IDX_W - 2;
    localparam int ENTRY_W = 1 + TAG_W + PC_W + 1 + 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic             jump;
        logic [1:0]       ctr;
    } btb_entry_t;

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // BTB
    // ------------------------------------------------------------------
    btb_entry_t       f_entry, ex_entry, wr_entry;
    logic             wr_en;
    logic [IDX_W-1:0] f_idx, ex_idx;
    logic [TAG_W-1:0] f_tag, ex_tag;

    assign f_idx  = bus.f_pc[IDX_W+1:2];
    assign f_tag  = bus.f_pc[PC_W-1:IDX_W+2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[PC_W-1:IDX_W+2];

    branch_target_buffer #(
        .ENTRY_W (ENTRY_W),
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_a_idx_i   (f_idx),
        .rd_a_entry_o (f_entry),
        .rd_b_idx_i   (ex_idx),
        .rd_b_entry_o (ex_entry),
        .wr_en_i      (wr_en),
        .wr_idx_i     (ex_idx),
        .wr_entry_i   (wr_entry)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bpu_state_e       state_q, state_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic f_hit, f_take;

    assign f_hit  = f_entry.valid && (f_entry.tag == f_tag);
    assign f_take = rst_n && (state_q == RUN) && f_hit && (f_entry.jump || f_entry.ctr[1]);

    assign bus.f_pred_taken  = f_take;
    assign bus.f_pred_target = f_take ? f_entry.target : '0;

    // ------------------------------------------------------------------
    // EX resolve
    // ------------------------------------------------------------------
    logic            is_ctrl, halt_evt, resolve;
    logic            actual_taken, mispredict, ex_hit;
    logic [PC_W-1:0] actual_target, pc_four;

    assign is_ctrl  = bus.ex_branch | bus.ex_jal | bus.ex_jalr;
    // Halt wins over any class bit raised together with it.
    assign halt_evt = bus.ex_valid && (state_q == RUN) && bus.ex_halt;
    assign resolve  = bus.ex_valid && (state_q == RUN) && !bus.ex_halt && is_ctrl;

    assign actual_taken  = bus.ex_jal | bus.ex_jalr | (bus.ex_branch & bus.ex_alu_result[0]);
    assign actual_target = bus.ex_jalr ? {bus.ex_alu_result[PC_W-1:1], 1'b0}
                                       : bus.ex_pc + bus.ex_imm[PC_W-1:0];
    assign pc_four       = bus.ex_pc + PC_W'(4);
    assign mispredict    = (bus.ex_pred_taken != actual_taken) ||
                           (actual_taken && (bus.ex_pred_target != actual_target));
    assign ex_hit        = ex_entry.valid && (ex_entry.tag == ex_tag);

    // ------------------------------------------------------------------
    // FSM, redirect
    // ------------------------------------------------------------------
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            halt_pc_q     <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            halt_pc_q     <= halt_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_pc_d   = halt_pc_q;
        redirect    = 1'b0;
        redirect_pc = pc_four;
        case (state_q)
            RUN: begin
                if (halt_evt) begin
                    state_d     = HALT;
                    halt_pc_d   = bus.ex_pc;
                    redirect    = 1'b1;
                    redirect_pc = bus.ex_pc;
                end else if (resolve) begin
                    redirect    = mispredict;
                    redirect_pc = actual_taken ? actual_target : pc_four;
                end
            end
            HALT: begin
                redirect    = 1'b1;
                redirect_pc = halt_pc_q;
            end
            default: state_d = RUN;
        endcase
        if (!rst_n) redirect = 1'b0;
    end

    // ------------------------------------------------------------------
    // Table update and perf counters
    // ------------------------------------------------------------------
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (resolve) begin
            if (ex_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_next(ex_entry.ctr, actual_taken);
                if (actual_taken) begin
                    wr_entry.target = actual_target;
                    wr_entry.jump   = bus.ex_jal | bus.ex_jalr;
                end
            end else if (actual_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = ex_tag;
                wr_entry.target = actual_target;
                wr_entry.jump   = bus.ex_jal | bus.ex_jalr;
                wr_entry.ctr    = CTR_INIT;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && !(&branch_cnt_q))                 branch_cnt_d  = branch_cnt_q + 1'b1;
        if (resolve && mispredict && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    assign bus.redirect         = redirect;
    assign bus.flush            = redirect;
    assign bus.redirect_pc      = redirect_pc;
    assign bus.pc_four          = pc_four;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispred_cnt_q;

endmodule : branch_predict_unit
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Self-checking bench for branch_predict_unit. A reference
//                model produces expected outputs for every driven cycle; they
//                are queued and compared against the DUT mid-cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int PC_W    = 9;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_predict_unit #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic            m_valid  [ENTRIES];
    logic [2:0]      m_tag    [ENTRIES];
    logic [PC_W-1:0] m_target [ENTRIES];
    logic            m_jump   [ENTRIES];
    logic [1:0]      m_ctr    [ENTRIES];
    logic            m_halted;
    logic [PC_W-1:0] m_halt_pc;
    logic [31:0]     m_bc, m_mc;
    logic            m_in_reset;

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:       return 64'(bus.f_pred_taken);
            1:       return 64'(bus.f_pred_target);
            2:       return 64'(bus.redirect);
            3:       return 64'(bus.redirect_pc);
            4:       return 64'(bus.flush);
            5:       return 64'(bus.pc_four);
            6:       return 64'(bus.branch_count);
            default: return 64'(bus.mispredict_count);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic clear_model();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_jump[i]   = 1'b0;
            m_ctr[i]    = 2'd0;
        end
        m_halted  = 1'b0;
        m_halt_pc = '0;
        m_bc      = '0;
        m_mc      = '0;
    endtask

    // One cycle: drive at negedge, check 2ns later, then advance the model
    // to what the following rising edge should commit.
    task automatic step(input string name, input logic v, input logic br, input logic jl,
                        input logic jr, input logic hl, input logic [PC_W-1:0] pc,
                        input logic [31:0] imm, input logic [31:0] alu, input logic pt,
                        input logic [PC_W-1:0] ptg, input logic [PC_W-1:0] fpc);
        logic [3:0]      fi, ei;
        logic            fhit, ptk, ctrl, a_taken, misp, redir, ehit;
        logic [PC_W-1:0] a_tgt, pf, rpc;
        exp_t            e;

        @(negedge clk);
        bus.ex_valid       = v;
        bus.ex_branch      = br;
        bus.ex_jal         = jl;
        bus.ex_jalr        = jr;
        bus.ex_halt        = hl;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.ex_alu_result  = alu;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptg;
        bus.f_pc           = fpc;

        fi   = fpc[5:2];
        fhit = m_valid[fi] && (m_tag[fi] == fpc[8:6]);
        ptk  = !m_in_reset && !m_halted && fhit && (m_jump[fi] || m_ctr[fi][1]);

        ctrl    = br | jl | jr;
        a_taken = jl | jr | (br & alu[0]);
        a_tgt   = jr ? {alu[PC_W-1:1], 1'b0} : pc + imm[PC_W-1:0];
        pf      = pc + 9'd4;
        misp    = (pt != a_taken) || (a_taken && (ptg != a_tgt));

        redir = 1'b0;
        rpc   = '0;
        if (m_in_reset) begin
            redir = 1'b0;
        end else if (m_halted) begin
            redir = 1'b1;
            rpc   = m_halt_pc;
        end else if (v && hl) begin
            redir = 1'b1;
            rpc   = pc;
        end else if (v && ctrl) begin
            redir = misp;
            rpc   = a_taken ? a_tgt : pf;
        end

        push({name, "/f_pred_taken"}, 0, 64'(ptk));
        push({name, "/f_pred_target"}, 1, ptk ? 64'(m_target[fi]) : 64'd0);
        push({name, "/redirect"}, 2, 64'(redir));
        push({name, "/flush"}, 4, 64'(redir));
        if (redir) push({name, "/redirect_pc"}, 3, 64'(rpc));
        if (!m_in_reset) begin
            push({name, "/pc_four"}, 5, 64'(pf));
            push({name, "/branch_count"}, 6, 64'(m_bc));
            push({name, "/mispredict_count"}, 7, 64'(m_mc));
        end

        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end

        if (!m_in_reset && !m_halted && v) begin
            if (hl) begin
                m_halted  = 1'b1;
                m_halt_pc = pc;
            end else if (ctrl) begin
                m_bc = m_bc + 1;
                if (misp) m_mc = m_mc + 1;
                ei   = pc[5:2];
                ehit = m_valid[ei] && (m_tag[ei] == pc[8:6]);
                if (ehit) begin
                    if (a_taken) begin
                        if (m_ctr[ei] != 2'd3) m_ctr[ei] = m_ctr[ei] + 2'd1;
                        m_target[ei] = a_tgt;
                        m_jump[ei]   = jl | jr;
                    end else begin
                        if (m_ctr[ei] != 2'd0) m_ctr[ei] = m_ctr[ei] - 2'd1;
                    end
                end else if (a_taken) begin
                    m_valid[ei]  = 1'b1;
                    m_tag[ei]    = pc[8:6];
                    m_target[ei] = a_tgt;
                    m_jump[ei]   = jl | jr;
                    m_ctr[ei]    = 2'd2;
                end
            end
        end
    endtask

    task automatic idle(input string name, input logic [PC_W-1:0] fpc);
        step(name, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 32'd0, 1'b0, '0, fpc);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset      = 1'b0;
        m_in_reset = 1'b1;
        clear_model();
        idle(name, 9'h010);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        m_in_reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b0;
        m_in_reset         = 1'b1;
        bus.f_pc           = '0;
        bus.ex_valid       = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_branch      = 1'b0;
        bus.ex_jal         = 1'b0;
        bus.ex_jalr        = 1'b0;
        bus.ex_halt        = 1'b0;
        bus.ex_imm         = '0;
        bus.ex_alu_result  = '0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = '0;
        clear_model();

        do_reset("rst0");

        // Cold lookup after reset
        idle("t1_idle", 9'h040);

        // Taken branch, predicted not taken -> redirect to 0x030
        step("t2_br", 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h1, 0, 9'h000, 9'h040);
        idle("t2_look", 9'h010);

        // Alias at index 4 with a different tag, then eviction
        idle("t3_alias_miss", 9'h050);
        step("t3_evict", 1, 1, 0, 0, 0, 9'h050, 32'h10, 32'h1, 0, 9'h000, 9'h050);
        idle("t3_old_gone", 9'h010);
        idle("t3_new_hit", 9'h050);

        // Reallocate 0x010, saturate, then one not-taken
        step("t4_realloc", 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h1, 0, 9'h000, 9'h010);
        for (int i = 0; i < 3; i++)
            step("t4_sat", 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h1, 1, 9'h030, 9'h010);
        step("t4_nt", 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h0, 1, 9'h030, 9'h010);
        idle("t4_still_taken", 9'h010);

        // JALR with odd target, then lookup sees jump entry
        step("t5_jalr", 1, 0, 0, 1, 0, 9'h020, 32'h0, 32'h123, 0, 9'h000, 9'h020);
        idle("t5_look", 9'h020);
        step("t5_jalr_ok", 1, 0, 0, 1, 0, 9'h020, 32'h0, 32'h123, 1, 9'h122, 9'h020);

        // Wrapping JAL, wrong-target branch, non-control, invalid EX
        step("t7_jal_wrap", 1, 0, 1, 0, 0, 9'h1FC, 32'h8, 32'h0, 0, 9'h000, 9'h1FC);
        idle("t7_wrap_look", 9'h1FC);
        step("t7_bad_tgt", 1, 1, 0, 0, 0, 9'h010, 32'h24, 32'h1, 1, 9'h030, 9'h010);
        step("t7_nonctrl", 1, 0, 0, 0, 0, 9'h080, 32'h4, 32'h1, 1, 9'h100, 9'h010);
        step("t7_invalid", 0, 1, 0, 0, 0, 9'h080, 32'h4, 32'h1, 0, 9'h000, 9'h010);

        // Halt (with branch bit) is sticky until reset
        step("t6_halt", 1, 1, 0, 0, 1, 9'h0A0, 32'h10, 32'h1, 0, 9'h000, 9'h010);
        step("t6_halt_br", 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h1, 0, 9'h000, 9'h010);
        step("t6_halt_jal", 1, 0, 1, 0, 0, 9'h040, 32'h40, 32'h0, 0, 9'h000, 9'h020);
        idle("t6_halt_idle", 9'h050);
        do_reset("t6_rst");
        idle("t6_after_rst", 9'h010);
        idle("t6_after_rst2", 9'h020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_branch_predict_unit
`default_nettype wire
